// File: rtl/pipelined_adder_pkg.sv
// Shared ALU constants for the pipelined adder.
// Holds the default operand/chunk widths, the encoding of the sub pin
// and the signed-overflow helper used by the final pipeline stage.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 16;

    // Encoding of the sub pin.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement overflow: both operands share a sign that the result lacks.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: purely combinational W-bit ripple add.
// Ports: a, b (W-bit addends), ci (carry in), s (W-bit sum), co (carry out).
module adder_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into WIDTH/CHUNK ripple
// chunks, one register stage per chunk, with a valid/ready handshake.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   in1, in2, cIn, sub  operands; sub=1 computes in1 - in2 and ignores cIn
//   out_valid/out_ready result handshake
//   sum, cOut, ovf,zero registered result and flags
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cIn,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic             ovf_r;
    logic             zero_r;

    // Subtraction is A + ~B + 1, so the carry-in is forced high.
    assign b_eff_s = (sub == OP_SUB) ? ~in2 : in2;
    assign c0_s    = (sub == OP_SUB) ? 1'b1 : cIn;

    // The whole pipe advances together; a held result freezes every stage.
    assign en_s     = ~out_valid | out_ready;
    assign in_ready = en_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still waiting for their chunk shrink by CHUNK per stage,
        // completed sum bits grow by CHUNK per stage.
        localparam int AW = (STAGES - k) * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [AW-1:0]    a_src_s;
        logic [AW-1:0]    b_src_s;
        logic             c_src_s;
        logic             v_src_s;
        logic [CHUNK-1:0] chunk_s;
        logic             chunk_co_s;
        logic [SW-1:0]    s_next_s;
        logic [SW-1:0]    s_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_head
            assign a_src_s  = in1;
            assign b_src_s  = b_eff_s;
            assign c_src_s  = c0_s;
            assign v_src_s  = in_valid;
            assign s_next_s = chunk_s;
        end else begin : g_tail
            assign a_src_s  = g_stage[k-1].g_skew.a_r;
            assign b_src_s  = g_stage[k-1].g_skew.b_r;
            assign c_src_s  = g_stage[k-1].c_r;
            assign v_src_s  = g_stage[k-1].v_r;
            assign s_next_s = {chunk_s, g_stage[k-1].s_r};
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a  (a_src_s[CHUNK-1:0]),
            .b  (b_src_s[CHUNK-1:0]),
            .ci (c_src_s),
            .s  (chunk_s),
            .co (chunk_co_s)
        );

        // Stage valid, carry and accumulated lower sum chunks.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= {SW{1'b0}};
            end else if (en_s) begin
                v_r <= v_src_s;
                c_r <= chunk_co_s;
                s_r <= s_next_s;
            end
        end

        if (k < LAST) begin : g_skew
            logic [AW-CHUNK-1:0] a_r;
            logic [AW-CHUNK-1:0] b_r;

            // Skew registers carry the not-yet-added upper operand chunks forward.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= {(AW-CHUNK){1'b0}};
                    b_r <= {(AW-CHUNK){1'b0}};
                end else if (en_s) begin
                    a_r <= a_src_s[AW-1:CHUNK];
                    b_r <= b_src_s[AW-1:CHUNK];
                end
            end
        end
    end

    // Flags are derived from the full result as it enters the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b1;
        end else if (en_s) begin
            ovf_r  <= signed_ovf(g_stage[LAST].a_src_s[CHUNK-1],
                                 g_stage[LAST].b_src_s[CHUNK-1],
                                 g_stage[LAST].s_next_s[WIDTH-1]);
            zero_r <= ~|g_stage[LAST].s_next_s;
        end
    end

    assign out_valid = g_stage[LAST].v_r;
    assign sum       = g_stage[LAST].s_r;
    assign cOut      = g_stage[LAST].c_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 32/16 instance for directed
// vectors, backpressure and reset, and a 64/8 instance for the deep pipe.
module tb_pipelined_adder;

    typedef struct {
        logic [63:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q32[$];
    exp_t        q64[$];

    logic        v32 = 1'b0, r32, ci32 = 1'b0, sb32 = 1'b0, ov32, or32 = 1'b1, co32, of32, z32;
    logic [31:0] a32 = 32'd0, b32 = 32'd0, s32;
    logic        v64 = 1'b0, r64, ci64 = 1'b0, sb64 = 1'b0, ov64, or64 = 1'b1, co64, of64, z64;
    logic [63:0] a64 = 64'd0, b64 = 64'd0, s64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder #(.WIDTH(32), .CHUNK(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in1(a32), .in2(b32),
        .cIn(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cOut(co32), .ovf(of32), .zero(z32));

    pipelined_adder #(.WIDTH(64), .CHUNK(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in1(a64), .in2(b64),
        .cIn(ci64), .sub(sb64), .out_valid(ov64), .out_ready(or64), .sum(s64),
        .cOut(co64), .ovf(of64), .zero(z64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t model64(input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sb);
        exp_t        e;
        logic [63:0] bp;
        logic [64:0] r;
        bp    = sb ? ~b : b;
        r     = {1'b0, a} + {1'b0, bp} + {64'd0, (sb ? 1'b1 : cin)};
        e.sum = r[63:0];
        e.co  = r[64];
        e.ov  = (a[63] == bp[63]) && (r[63] != a[63]);
        e.z   = (r[63:0] == 64'd0);
        e.acc = 0;
        e.lat = 1'b1;
        return e;
    endfunction

    // Offer one beat on the 32-bit DUT starting at a negedge; returns at the next negedge.
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                          input logic [31:0] es, input logic eco, input logic eov, input logic ez,
                          input bit lat);
        exp_t e;
        int   n;
        a32 = a; b32 = b; ci32 = ci; sb32 = sb; v32 = 1'b1;
        #1;
        n = 0;
        while (!r32 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!r32) begin
            total++; bad++;
            $display("FAIL accept32: in_ready stuck at 0");
        end else begin
            e.sum = {32'd0, es}; e.co = eco; e.ov = eov; e.z = ez; e.acc = cyc; e.lat = lat;
            q32.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb,
                          input exp_t e_in);
        exp_t e;
        e = e_in;
        a64 = a; b64 = b; ci64 = ci; sb64 = sb; v64 = 1'b1;
        #1;
        if (!r64) begin
            total++; bad++;
            $display("FAIL accept64: in_ready=%0b want 1", r64);
        end else begin
            e.acc = cyc;
            q64.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        v64 = 1'b0;
    endtask

    // Monitor for the 32-bit DUT: hold stability, result and latency checks.
    logic [34:0] snap32;
    bit          hold32 = 1'b0;
    bit          seen32 = 1'b0;
    int          seen_cyc32 = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            hold32 = 1'b0; seen32 = 1'b0;
        end else if (ov32) begin
            if (!seen32) begin seen32 = 1'b1; seen_cyc32 = cyc; end
            if (hold32) chk("hold32", {29'd0, s32, co32, of32, z32}, {29'd0, snap32});
            if (q32.size() == 0) begin
                total++; bad++; seen32 = 1'b0;
                $display("FAIL unexpected32: sum=%h with empty scoreboard", s32);
            end else if (or32) begin
                e = q32.pop_front();
                chk("sum32", {32'd0, s32}, e.sum);
                chk("cout32", {63'd0, co32}, {63'd0, e.co});
                chk("ovf32", {63'd0, of32}, {63'd0, e.ov});
                chk("zero32", {63'd0, z32}, {63'd0, e.z});
                if (e.lat) chk("lat32", 64'(seen_cyc32 - e.acc), 64'd2);
                seen32 = 1'b0; hold32 = 1'b0;
            end else begin
                snap32 = {s32, co32, of32, z32};
                hold32 = 1'b1;
            end
        end else begin
            hold32 = 1'b0;
        end
    end

    // Monitor for the 64-bit DUT, always ready downstream.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && ov64) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected64: sum=%h with empty scoreboard", s64);
            end else begin
                e = q64.pop_front();
                chk("sum64", s64, e.sum);
                chk("cout64", {63'd0, co64}, {63'd0, e.co});
                chk("ovf64", {63'd0, of64}, {63'd0, e.ov});
                chk("zero64", {63'd0, z64}, {63'd0, e.z});
                chk("lat64", 64'(cyc - e.acc), 64'd8);
            end
        end
    end

    initial begin
        exp_t e;
        logic [63:0] ra, rb;
        logic        rc, rs;
        int          n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {63'd0, ov32}, 64'd0);
        chk("rst_sum", {32'd0, s32}, 64'd0);
        chk("rst_zero", {63'd0, z32}, 64'd1);
        chk("rst_flags", {62'd0, co32, of32}, 64'd0);
        chk("rst_ready", {63'd0, r32}, 64'd1);
        @(negedge clk);

        // Directed vectors, each with latency checked.
        send32(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        send32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
        send32(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        send32(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);
        send32(32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Backpressure: four beats while the consumer stalls for five cycles.
        fork
            begin
                send32(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                send32(32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
                send32(32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
                send32(32'd4, 32'd4, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            begin
                or32 = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                chk("bp_in_ready", {63'd0, r32}, 64'd0);
                repeat (2) @(negedge clk);
                or32 = 1'b1;
            end
        join
        repeat (6) @(negedge clk);

        // Reset with two beats in flight.
        or32 = 1'b0;
        send32(32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        send32(32'd11, 32'd21, 1'b0, 1'b0, 32'd32, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q32.delete();
        or32 = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, ov32}, 64'd0);
        chk("mid_rst_sum", {32'd0, s32}, 64'd0);
        chk("mid_rst_zero", {63'd0, z32}, 64'd1);
        chk("mid_rst_ready", {63'd0, r32}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_idle", {63'd0, ov32}, 64'd0);
        end
        @(negedge clk);
        send32(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b1);

        // Deep pipe: carry across all eight chunks, then back-to-back beats.
        e = model64(64'h00FFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0);
        chk("model64_dir", e.sum, 64'h0100000000000000);
        send64(64'h00FFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, e);
        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            send64(ra, rb, rc, rs, model64(ra, rb, rc, rs));
        end
        send64(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, model64(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0));

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (q32.size() != 0 || q64.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d/%0d results never appeared", q32.size(), q64.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit two-chunk ripple adder.
- Splits a WIDTH-bit add or subtract into WIDTH/CHUNK ripple chunks, with one register stage per chunk.
- Carries a valid/ready handshake with full backpressure.
- Used in the ALU datapath wherever a wide adder must close timing at clock rate.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 16: bits added per pipeline stage. WIDTH % CHUNK must be 0; elaboration fails otherwise.
- STAGES, WIDTH/CHUNK: derived pipeline depth (localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cIn  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = A - B, 0 = A + B + cIn.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cOut  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- **Effective operands:**
  - B' = sub ? ~in2 : in2.
  - c0 = sub ? 1 : cIn.
  - Result = in1 + B' + c0, taken modulo 2^WIDTH; the carry goes to cOut.
- **Stage k (0..STAGES-1):**
  - Adds chunk k of A and B' plus the registered carry from stage k-1 (stage 0 uses c0).
  - Registers the chunk sum and its carry.
- **Skew registers:**
  - Upper operand chunks are delayed to meet their carries.
  - Completed lower sum chunks are delayed to meet the last stage.
- **Stall rule:**
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en, combinational.
  - When en=0, every pipeline register holds, including the valid bits.
- **Valid pipeline:**
  - One valid bit per stage; stage 0 loads in_valid & en.
  - in_valid=0 with en=1 inserts a bubble.
  - Bubbles advance and are never squeezed out.
- **Latency:**
  - A beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES, absent stalls.
  - Throughput is one beat per cycle.
- **Flags:**
  - Computed in the final stage from the full result.
  - ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
  - zero = ~|sum.
- **Output hold:** outputs are stable while out_valid=1 and out_ready=0.
- **Reset:**
  - All valid bits = 0, out_valid = 0, sum = 0, cOut = ovf = 0, zero = 1.
  - Skew and partial registers are cleared to 0.
  - in_ready = 1 in the cycle after reset deasserts.
- **Reset mid-operation:** all in-flight beats are discarded with no output; rst has priority over en.
- **Simultaneous events:**
  - When out_valid & out_ready & in_valid all hold, the pipeline advances.
  - The new beat is accepted and the old result is consumed in the same cycle.
- **Degenerate configuration:** STAGES=1 gives a single-register adder with latency 1.

Decomposition:
- Shared ALU package holds:
  - the default WIDTH/CHUNK constants;
  - the op encoding OP_ADD=0, OP_SUB=1 for the sub pin.
- One sub-module, adder_chunk: combinational CHUNK-bit a + b + ci giving {co, s}.
  - Instantiated STAGES times via generate.
- Pipeline, skew and flag logic live in pipelined_adder.

Test Plan (WIDTH=32, CHUNK=16, latency 2 unless stated):
1. Cross-chunk carry: 0x0000FFFF + 0x00000001, cIn=0, sub=0 -> sum=0x00010000, cOut=0, ovf=0, out_valid 2 cycles after accept.
2. Signed overflow: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cOut=0. Then 0xFFFFFFFF + 0x00000001 -> sum=0, cOut=1, zero=1, ovf=0.
3. Subtract: 5 - 7 -> sum=0xFFFFFFFE, cOut=0, ovf=0. 0x80000000 - 1 -> 0x7FFFFFFF, ovf=1. cIn=1 with sub=1 is ignored (7 - 5 = 2).
4. Backpressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles.
   - in_ready drops after the pipe fills.
   - After release, results 2, 4, 6, 8 appear in order, with none lost or duplicated.
   - Held outputs are stable throughout.
5. Reset mid-flight: accept 2 beats, assert rst one cycle -> no out_valid thereafter; sum=0, zero=1; next beat has latency 2.
6. Reparametrised WIDTH=64, CHUNK=8 -> 0x00FFFFFFFFFFFFFF + 1 = 0x0100000000000000 at latency 8; back-to-back random beats match a reference model.
